ifetch: RTL

Instruction-fetch stage sitting between the PC register and the decode stage. Consumes the PC value, issues instruction-ROM requests over a req/gnt/rvalid handshake, buffers returned instructions with their addresses, and presents them to decode with a valid/ready handshake. Back-pressures the PC register with a hold signal and discards wrong-path instructions when ctrl signals a jump.

---
 rtl/ifetch_pkg.sv | 15 +
 rtl/ifetch_fifo.sv | 49 ++++
 rtl/ifetch.sv | 81 ++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared widths, reset constants and FIFO entry layouts for the fetch stage
package ifetch_pkg;
  localparam int ADDR_W = 32;
  localparam int INST_W = 32;
  localparam logic [ADDR_W-1:0] RST_PC = 32'h0000_0000;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;
  typedef struct packed {
    logic kill;
    logic [ADDR_W-1:0] pc;
  } ifl_t;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [INST_W-1:0] inst;
  } ibuf_t;
endpackage

// File: rtl/ifetch_fifo.sv
// sync_fifo: power-of-two circular FIFO with simultaneous push/pop and a synchronous flush
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  always_comb begin
    empty_o = cnt_q == '0;
    rdata_o = mem_q[rd_q];
    cnt_o = cnt_q;
    do_pop = pop_i && !empty_o;
    do_push = push_i && (cnt_q != FULL_C || do_pop);
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = wdata_i;
    wr_d = flush_i ? '0 : wr_q + AW'(do_push);
    rd_d = flush_i ? '0 : rd_q + AW'(do_pop);
    cnt_d = flush_i ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/ifetch.sv
// ifetch: credit-limited instruction fetch between the PC register and decode
// with in-order ROM responses, a registered instruction buffer and jump flush.
module ifetch
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_addr_i,
  input  logic              jump_en_i,
  output logic              pc_hold_o,
  output logic              rom_req_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic              rom_gnt_i,
  input  logic              rom_rvalid_i,
  input  logic [INST_W-1:0] rom_rdata_i,
  output logic              inst_valid_o,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  input  logic              inst_ready_i
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  logic [CW-1:0] cnt_q, cnt_d, if_cnt, buf_cnt;
  logic [DEPTH-1:0] kill_q, kill_d, kill_sh, new_slot;
  ifl_t if_head, if_wdata;
  ibuf_t buf_head, buf_wdata;
  logic if_empty, buf_empty, acc, rsp, drop, buf_push, pop;
  always_comb begin
    inst_valid_o = !buf_empty && !jump_en_i;
    pop = inst_valid_o && inst_ready_i;
    rom_req_o = !rst && !jump_en_i && (cnt_q < DEPTH_C || pop);
    rom_addr_o = pc_addr_i;
    acc = rom_req_o && rom_gnt_i;
    pc_hold_o = !acc && !jump_en_i;
    rsp = rom_rvalid_i && !if_empty;
    drop = rsp && (if_head.kill || kill_q[0] || jump_en_i);
    buf_push = rsp && !drop;
    if_wdata = '{kill: 1'b0, pc: pc_addr_i};
    buf_wdata = '{addr: if_head.pc, inst: rom_rdata_i};
    cnt_d = cnt_q + CW'(acc) - CW'(pop) - CW'(drop) - (jump_en_i ? buf_cnt : '0);
    // kill bits are kept head-aligned: shift on response, clear the slot a new entry lands in
    kill_sh = rsp ? kill_q >> 1 : kill_q;
    new_slot = {{(DEPTH-1){1'b0}}, acc} << (if_cnt - CW'(rsp));
    kill_d = jump_en_i ? '1 : kill_sh & ~new_slot;
    inst_o = buf_head.inst;
    inst_addr_o = buf_head.addr;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      kill_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      kill_q <= kill_d;
    end
  end
  sync_fifo #(.WIDTH(ADDR_W + 1), .DEPTH(DEPTH)) u_ifl (
    .clk     (clk),
    .rst     (rst),
    .flush_i (1'b0),
    .push_i  (acc),
    .wdata_i (if_wdata),
    .pop_i   (rsp),
    .rdata_o (if_head),
    .empty_o (if_empty),
    .cnt_o   (if_cnt)
  );
  sync_fifo #(.WIDTH(ADDR_W + INST_W), .DEPTH(DEPTH)) u_ibuf (
    .clk     (clk),
    .rst     (rst),
    .flush_i (jump_en_i),
    .push_i  (buf_push),
    .wdata_i (buf_wdata),
    .pop_i   (pop),
    .rdata_o (buf_head),
    .empty_o (buf_empty),
    .cnt_o   (buf_cnt)
  );
endmodule
